// File: rtl/adc_sample_arbiter.sv
// adc_sample_arbiter: merges left/right ADC sample strobes into one tagged valid/ready stream.
// Word layout {ch, ovr, seq, sample}; ch 0 = left, 1 = right.
// Optional overrun statistics counters are enabled by defining ADC_SAMPLE_ARBITER_STATS_EN.
module adc_sample_arbiter #(
    parameter int DATA_WIDTH = 12,
    parameter int SEQ_WIDTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [DATA_WIDTH-1:0]             ldata,
    input  logic                              lstrb,
    input  logic [DATA_WIDTH-1:0]             rdata,
    input  logic                              rstrb,
    output logic [DATA_WIDTH+SEQ_WIDTH+1:0]   m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [CNT_WIDTH-1:0]              lovr_cnt,
    output logic [CNT_WIDTH-1:0]              rovr_cnt
);
    logic [1:0]            strb, full, ovr, gnt, ovr_ev;
    logic [DATA_WIDTH-1:0] din [2];
    logic [DATA_WIDTH-1:0] sdata [2];
    logic [SEQ_WIDTH-1:0]  sseq [2];
    logic [SEQ_WIDTH-1:0]  seq [2];
    logic                  ptr, load, sel;

    assign strb   = {rstrb, lstrb} & {2{enable}};
    assign din[0] = ldata;
    assign din[1] = rdata;
    assign load   = !m_valid || m_ready;
    assign sel    = gnt[1];

    // Round-robin grant: a lone full slot wins, the pointer breaks ties.
    always_comb begin
        gnt[0] = load && full[0] && (!full[1] || !ptr);
        gnt[1] = load && full[1] && (!full[0] || ptr);
        ovr_ev = strb & full & ~gnt;
    end

    // Per-channel slot capture, sequence numbering and sticky overrun flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full <= '0;
            ovr  <= '0;
            for (int i = 0; i < 2; i++) begin
                sdata[i] <= '0;
                sseq[i]  <= '0;
                seq[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (strb[i]) begin
                    full[i]  <= 1'b1;
                    sdata[i] <= din[i];
                    sseq[i]  <= seq[i];
                    seq[i]   <= seq[i] + SEQ_WIDTH'(1);
                end else if (gnt[i]) begin
                    full[i] <= 1'b0;
                end
                if (ovr_ev[i])
                    ovr[i] <= 1'b1;
                else if (gnt[i])
                    ovr[i] <= 1'b0;
            end
        end
    end

    // Output register and arbitration pointer; pointer moves only on contended grants.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            ptr     <= 1'b0;
        end else if (load) begin
            m_valid <= |full;
            if (|full)
                m_data <= {sel, ovr[sel], sseq[sel], sdata[sel]};
            if (&full)
                ptr <= !sel;
        end
    end

`ifdef ADC_SAMPLE_ARBITER_STATS_EN
    logic [CNT_WIDTH-1:0] cnt [2];

    // Saturating overrun event counters, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++)
                if (ovr_ev[i] && cnt[i] != '1)
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end
    end

    assign lovr_cnt = cnt[0];
    assign rovr_cnt = cnt[1];
`else
    assign lovr_cnt = '0;
    assign rovr_cnt = '0;
`endif
endmodule

// File: tb/tb_adc_sample_arbiter.sv
// tb_adc_sample_arbiter: scoreboard bench for adc_sample_arbiter.
module tb_adc_sample_arbiter;
    localparam int DW = 12;
    localparam int SW = 2;
    localparam int CW = 2;
`ifdef ADC_SAMPLE_ARBITER_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic              clock = 0;
    logic              reset = 1;
    logic              enable = 1;
    logic [DW-1:0]     ldata = '0, rdata = '0;
    logic              lstrb = 0, rstrb = 0;
    logic [DW+SW+1:0]  m_data;
    logic              m_valid;
    logic              m_ready = 1;
    logic [CW-1:0]     lovr_cnt, rovr_cnt;

    int errors = 0;
    int checks = 0;
    logic [DW+SW+1:0] exp_q [$];
    logic             hold = 0;
    logic [DW+SW+1:0] hold_data = '0;

    adc_sample_arbiter #(.DATA_WIDTH(DW), .SEQ_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .ldata(ldata), .lstrb(lstrb), .rdata(rdata), .rstrb(rstrb),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .lovr_cnt(lovr_cnt), .rovr_cnt(rovr_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW+SW+1:0] word(input logic ch, input logic o, input logic [SW-1:0] s, input logic [DW-1:0] d);
        return {ch, o, s, d};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic l, input logic [DW-1:0] ld, input logic r, input logic [DW-1:0] rd);
        lstrb = l; ldata = ld; rstrb = r; rdata = rd;
        tick(1);
        lstrb = 0; rstrb = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick(2);
        reset = 0;
        tick(1);
    endtask

    // Monitor: transfers pop the scoreboard, stalled words must stay put.
    always @(negedge clock) begin
        if (reset) begin
            hold <= 0;
        end else begin
            if (hold) begin
                check("stall_valid", 32'(m_valid), 1);
                check("stall_data", 32'(m_data), 32'(hold_data));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0)
                    check("spurious_word", 32'(m_data), 32'hFFFF_FFFF);
                else
                    check("word", 32'(m_data), 32'(exp_q.pop_front()));
            end
            hold <= m_valid && !m_ready;
            hold_data <= m_data;
        end
    end

    initial begin
        tick(2);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_data", 32'(m_data), 0);
        check("rst_lcnt", 32'(lovr_cnt), 0);
        check("rst_rcnt", 32'(rovr_cnt), 0);
        reset = 0;
        tick(1);

        // Single left sample: latency of two cycles, one-cycle valid.
        exp_q.push_back(word(0, 0, 0, 12'hABC));
        strobe(1, 12'hABC, 0, 0);
        @(negedge clock); check("lat_t1", 32'(m_valid), 0);
        @(negedge clock); check("lat_t2", 32'(m_valid), 1);
        @(negedge clock); check("lat_t3", 32'(m_valid), 0);
        tick(1);
        exp_q.push_back(word(0, 0, 1, 12'h123));
        strobe(1, 12'h123, 0, 0);
        tick(4);

        // Simultaneous pairs: left first, then pointer gives right first.
        do_reset();
        exp_q.push_back(word(0, 0, 0, 12'h111));
        exp_q.push_back(word(1, 0, 0, 12'h222));
        strobe(1, 12'h111, 1, 12'h222);
        tick(4);
        exp_q.push_back(word(1, 0, 1, 12'h444));
        exp_q.push_back(word(0, 0, 1, 12'h333));
        strobe(1, 12'h333, 1, 12'h444);
        tick(4);

        // Overrun while stalled.
        do_reset();
        m_ready = 0;
        strobe(1, 12'h001, 0, 0);
        strobe(1, 12'h002, 0, 0);
        strobe(1, 12'h003, 0, 0);
        tick(2);
        check("ovr_hold_valid", 32'(m_valid), 1);
        check("ovr_hold_data", 32'(m_data), 32'(word(0, 0, 0, 12'h001)));
        check("ovr_lcnt", 32'(lovr_cnt), STATS);
        exp_q.push_back(word(0, 0, 0, 12'h001));
        exp_q.push_back(word(0, 1, 2, 12'h003));
        m_ready = 1;
        tick(3);
        exp_q.push_back(word(0, 0, 3, 12'h004));
        strobe(1, 12'h004, 0, 0);
        tick(4);

        // Disabled strobes are ignored.
        do_reset();
        enable = 0;
        strobe(1, 12'hFFF, 1, 12'hEEE);
        strobe(1, 12'hDDD, 1, 12'hCCC);
        tick(3);
        check("dis_valid", 32'(m_valid), 0);
        enable = 1;
        exp_q.push_back(word(0, 0, 0, 12'h0AA));
        strobe(1, 12'h0AA, 0, 0);
        tick(4);

        // Async reset with a held word and both slots full.
        do_reset();
        m_ready = 0;
        strobe(1, 12'h5A5, 1, 12'hA5A);
        strobe(1, 12'h5A6, 0, 0);
        check("pre_rst_valid", 32'(m_valid), 1);
        #1 reset = 1;
        #1;
        check("async_valid", 32'(m_valid), 0);
        check("async_data", 32'(m_data), 0);
        tick(2);
        reset = 0;
        m_ready = 1;
        tick(5);
        check("post_rst_valid", 32'(m_valid), 0);
        exp_q.push_back(word(1, 0, 0, 12'h777));
        strobe(0, 0, 1, 12'h777);
        tick(4);

        // Right-channel overrun counter saturation.
        do_reset();
        m_ready = 0;
        for (int i = 1; i <= 6; i++)
            strobe(0, 0, 1, 12'(12'h600 + i));
        tick(1);
        check("sat_rcnt", 32'(rovr_cnt), STATS ? 3 : 0);
        check("sat_lcnt", 32'(lovr_cnt), 0);
        exp_q.push_back(word(1, 0, 0, 12'h601));
        exp_q.push_back(word(1, 1, 1, 12'h606));
        m_ready = 1;
        tick(5);
        check("sat_rcnt_hold", 32'(rovr_cnt), STATS ? 3 : 0);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adc_sample_arbiter.md
Name: adc_sample_arbiter

Overview:
- Shares one valid/ready output stream between the left and right ADC channel outputs of the dual MCP3201 front end (12-bit data plus a one-cycle strobe per channel).
- Buffers one sample per channel, arbitrates round-robin and tags each word with channel, overrun flag and sequence number.
- Sits between the ADC front end and the downstream packer/UART/FIFO, which may stall via ready.

Parameters:
- DATA_WIDTH, 12: sample width.
- SEQ_WIDTH, 2: per-channel sequence counter width.
- CNT_WIDTH, 16: overrun statistics counter width; used only with the optional feature.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when 0, incoming strobes are ignored; buffered data still drains.
- ldata  in  DATA_WIDTH  left sample, valid when lstrb=1.
- lstrb  in  1  left sample strobe, one cycle.
- rdata  in  DATA_WIDTH  right sample, valid when rstrb=1.
- rstrb  in  1  right sample strobe, one cycle.
- m_data  out  DATA_WIDTH+SEQ_WIDTH+2  output word: {ch, ovr, seq, sample}. ch is 0 for left, 1 for right.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- lovr_cnt  out  CNT_WIDTH  left overrun count.
- rovr_cnt  out  CNT_WIDTH  right overrun count.

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_data=0, both slots empty, sequence counters=0, sticky overrun flags=0, round-robin pointer = left first, counters=0. Reset mid-transfer discards all buffered and in-flight data.
- Capture:
  - A strobe with enable=1 writes data into that channel's slot, marks the slot full, stores the current seq, then increments seq (mod 2^SEQ_WIDTH).
  - seq increments on every accepted strobe, including overwriting ones, so dropped samples show as seq gaps.
  - Strobes with enable=0 change nothing.
- Overrun:
  - Condition: strobe arrives while the slot is full and the slot is not being granted in the same cycle.
  - Effect: newest sample overwrites the slot and the channel's sticky ovr is set.
  - ovr is copied into the next word emitted from that channel, then cleared at that grant. If a new overrun occurs in the same cycle as the grant, ovr stays set.
  - Strobe in the same cycle the slot is granted: the slot reloads with the new sample, no overrun.
- Output register:
  - Loads when (!m_valid || m_ready) and at least one slot is full.
  - One slot full: grant it.
  - Both slots full: grant the channel indicated by the pointer, then point to the other channel.
  - The pointer changes only on a grant with both slots full.
  - If the load condition holds and no slot is full, m_valid goes to 0.
- Latency: strobe in cycle t gives slot full at t+1, and m_valid at t+2 at the earliest (output free, no contention).
- Handshake:
  - m_data is stable while m_valid && !m_ready.
  - m_valid never drops without a transfer.
  - Back-to-back transfers sustain one word per cycle.
- Simultaneous lstrb and rstrb: both captured in the same cycle. The emission order follows the pointer.

Optional Feature:
- Macro: ADC_SAMPLE_ARBITER_STATS_EN.
- Defined:
  - lovr_cnt and rovr_cnt increment by 1 on each overrun event of their channel.
  - Each counter saturates at 2^CNT_WIDTH-1.
  - Both counters clear on reset only.
- Not defined: lovr_cnt and rovr_cnt are constant 0, and no counter flops are inferred. The ports remain so the wrapper is unchanged.

Test Plan:
- Single left strobe, ldata=12'hABC, m_ready=1 -> m_valid high two cycles later for one cycle; m_data={0,0,2'd0,12'hABC}; next left sample carries seq=1.
- Simultaneous lstrb/rstrb (12'h111/12'h222) after reset, m_ready=1 -> left word first, right word next cycle; a second simultaneous pair emits right first.
- m_ready=0, three left strobes 12'h001,12'h002,12'h003 -> output holds 12'h001 stably (seq 0). Release ready -> next word is 12'h003, seq=2, ovr=1, and lovr_cnt=1 with STATS_EN. The following left word has ovr=0.
- enable=0 with strobes on both channels -> no m_valid, seq unchanged. Set enable=1 and strobe -> seq=0 emitted.
- Assert reset while m_valid=1 and both slots full -> m_valid=0 immediately (async). After release, no stale words are emitted.
- STATS_EN, CNT_WIDTH=2, m_ready=0, six right strobes -> rovr_cnt saturates at 3. Without the macro -> rovr_cnt stays 0.
